// File: rtl/wb_arb_pkg.sv
// Shared definitions for the EFB Wishbone master arbiter: state encoding
// and the counter/index width helper.
package wb_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUS  = ST_BUS,
        GAP  = ST_GAP
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit after 'last',
// wrapping modulo NUM_REQ. Also used by the UART TX scheduler.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   winner_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = last_i;
        idx      = '0;
        // i runs to NUM_REQ so 'last' itself is checked last
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_i) + i) % NUM_REQ);
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing the EFB Wishbone slave port between NUM_REQ
// single-beat requesters, with a one-cycle idle gap and an ack timeout.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic [NUM_REQ-1:0]        i_Req,
    input  logic [NUM_REQ-1:0]        i_We,
    input  logic [NUM_REQ*ADDR_W-1:0] i_Addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_WrData,
    output logic [NUM_REQ-1:0]        o_Ack,
    output logic [NUM_REQ-1:0]        o_Err,
    output logic [DATA_W-1:0]         o_RdData,
    output logic                      o_Busy,
    output logic                      o_wb_cyc,
    output logic                      o_wb_stb,
    output logic                      o_wb_we,
    output logic [ADDR_W-1:0]         o_wb_adr,
    output logic [DATA_W-1:0]         o_wb_dat,
    input  logic [DATA_W-1:0]         i_wb_dat,
    input  logic                      i_wb_ack
);

    localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int CNT_W = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, busy_q, busy_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0]  dat_q, dat_d, rd_q, rd_d;
    logic [NUM_REQ-1:0] ack_q, ack_d, err_q, err_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]  addr_a [NUM_REQ];
    logic [DATA_W-1:0]  wdat_a [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_a[k] = i_Addr[k*ADDR_W +: ADDR_W];
        assign wdat_a[k] = i_WrData[k*DATA_W +: DATA_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i    (i_Req),
        .last_i   (last_q),
        .valid_o  (pick_vld),
        .winner_o (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rd_d    = rd_q;
        ack_d   = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    win_d   = pick_idx;
                    we_d    = i_We[pick_idx];
                    adr_d   = addr_a[pick_idx];
                    dat_d   = wdat_a[pick_idx];
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ack beats the final timeout count when both land together
                if (i_wb_ack) begin
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    we_d          = 1'b0;
                    if (!we_q) rd_d = i_wb_dat;
                    ack_d[win_q]  = 1'b1;
                    last_d        = win_q;
                    state_d       = GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    we_d          = 1'b0;
                    err_d[win_q]  = 1'b1;
                    last_d        = win_q;
                    state_d       = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rd_q    <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_Ack    = ack_q;
    assign o_Err    = err_q;
    assign o_RdData = rd_q;
    assign o_Busy   = busy_q;
    assign o_wb_cyc = cyc_q;
    assign o_wb_stb = stb_q;
    assign o_wb_we  = we_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Randomized bench for wb_master_arbiter against a transaction-level
// round-robin / timeout reference model.
module tb_wb_master_arbiter;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 64;

    logic              i_Clock = 1'b0;
    logic              i_Reset = 1'b1;
    logic [NR-1:0]     i_Req = '0;
    logic [NR-1:0]     i_We = '0;
    logic [NR*AW-1:0]  i_Addr = '0;
    logic [NR*DW-1:0]  i_WrData = '0;
    logic [NR-1:0]     o_Ack, o_Err;
    logic [DW-1:0]     o_RdData;
    logic              o_Busy, o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]     o_wb_adr;
    logic [DW-1:0]     o_wb_dat;
    logic [DW-1:0]     i_wb_dat = '0;
    logic              i_wb_ack = 1'b0;

    wb_master_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Req(i_Req), .i_We(i_We),
        .i_Addr(i_Addr), .i_WrData(i_WrData), .o_Ack(o_Ack), .o_Err(o_Err),
        .o_RdData(o_RdData), .o_Busy(o_Busy), .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
        .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
    );

    always #5 i_Clock = ~i_Clock;

    int ncmp = 0;
    int nerr = 0;
    int last_m = NR - 1;
    logic [DW-1:0] rd_m = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One transaction from the current negedge (arbiter idle). d = stb cycle
    // on which the slave acks (0 = first), d outside 0..TO-1 = never.
    task automatic txn(input logic [NR-1:0] mask, input logic [NR-1:0] we,
                       input logic [NR*AW-1:0] adr, input logic [NR*DW-1:0] wd,
                       input logic [DW-1:0] rdv, input int d, input bit drop,
                       output int win);
        bit acked;
        int idx;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic ewe;
        i_Req = mask; i_We = we; i_Addr = adr; i_WrData = wd;
        win = -1;
        for (int i = 1; i <= NR; i++) begin
            idx = (last_m + i) % NR;
            if (win < 0 && mask[idx]) win = idx;
        end
        eadr = adr[win*AW +: AW];
        edat = wd[win*DW +: DW];
        ewe  = we[win];
        acked = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge i_Clock);
            chk("bus_cyc", o_wb_cyc, 1);
            chk("bus_stb", o_wb_stb, 1);
            chk("bus_adr", o_wb_adr, eadr);
            chk("bus_we", o_wb_we, ewe);
            chk("bus_dat", o_wb_dat, edat);
            chk("bus_ack", o_Ack, 0);
            chk("bus_err", o_Err, 0);
            chk("bus_busy", o_Busy, 1);
            if (k == 0 && drop) begin
                i_Req[win] = 1'b0;
                i_We[win] = ~ewe;
                i_Addr[win*AW +: AW] = ~eadr;
                i_WrData[win*DW +: DW] = ~edat;
            end
            if (k == d) begin
                i_wb_ack = 1'b1;
                i_wb_dat = rdv;
                acked = 1'b1;
                break;
            end
        end
        @(negedge i_Clock);
        i_wb_ack = 1'b0;
        i_wb_dat = DW'($urandom);
        if (acked && !ewe) rd_m = rdv;
        chk("end_cyc", o_wb_cyc, 0);
        chk("end_stb", o_wb_stb, 0);
        if (acked) chk("end_we", o_wb_we, 0);
        chk("end_ack", o_Ack, acked ? (32'd1 << win) : 32'd0);
        chk("end_err", o_Err, acked ? 32'd0 : (32'd1 << win));
        chk("end_rd", o_RdData, rd_m);
        chk("end_busy", o_Busy, 1);
        last_m = win;
        @(negedge i_Clock);
        chk("gap_cyc", o_wb_cyc, 0);
        chk("gap_ack", o_Ack, 0);
        chk("gap_err", o_Err, 0);
        chk("gap_busy", o_Busy, 0);
    endtask

    initial begin
        int w;
        int r;
        int d;
        logic [AW-1:0] a0;
        repeat (2) @(negedge i_Clock);
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_stb", o_wb_stb, 0);
        chk("rst_we", o_wb_we, 0);
        chk("rst_adr", o_wb_adr, 0);
        chk("rst_ack", o_Ack, 0);
        chk("rst_err", o_Err, 0);
        chk("rst_rd", o_RdData, 0);
        chk("rst_busy", o_Busy, 0);
        i_Reset = 1'b0;

        // single read of 0x66 by requester 0
        txn(2'b01, 2'b00, {8'h00, 8'h66}, 16'h0000, 8'hA5, 0, 1'b0, w);
        chk("rd_win", w, 0);
        chk("rd_data", o_RdData, 8'hA5);

        // write 0x3C to 0x5E by requester 1
        txn(2'b10, 2'b10, {8'h5E, 8'h11}, {8'h3C, 8'h00}, 8'hFF, 1, 1'b0, w);
        chk("wr_win", w, 1);
        chk("wr_keep", o_RdData, 8'hA5);

        // contention: both held high, strict alternation
        for (int i = 0; i < 6; i++) begin
            a0 = AW'($urandom);
            txn(2'b11, NR'($urandom), {a0 ^ 8'h80, a0}, 16'($urandom),
                DW'($urandom), $urandom_range(0, 3), 1'b0, w);
            chk("cont_order", w, i % 2);
        end

        // timeout, then normal service
        txn(2'b01, 2'b00, {8'h22, 8'h44}, 16'h0, 8'h5A, -1, 1'b0, w);
        txn(2'b01, 2'b00, {8'h22, 8'h45}, 16'h0, 8'h6B, 0, 1'b0, w);
        chk("post_to_rd", o_RdData, 8'h6B);
        // ack on the final timeout cycle
        txn(2'b10, 2'b00, {8'h33, 8'h44}, 16'h0, 8'hC3, TO - 1, 1'b0, w);
        chk("last_ack_rd", o_RdData, 8'hC3);

        // reset three cycles into BUS
        i_Req = 2'b10; i_We = 2'b00; i_Addr = {8'h77, 8'h00};
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clock);
            chk("mid_cyc", o_wb_cyc, 1);
        end
        i_Reset = 1'b1;
        @(negedge i_Clock);
        chk("mrst_cyc", o_wb_cyc, 0);
        chk("mrst_stb", o_wb_stb, 0);
        chk("mrst_ack", o_Ack, 0);
        chk("mrst_err", o_Err, 0);
        chk("mrst_busy", o_Busy, 0);
        chk("mrst_rd", o_RdData, 0);
        i_Reset = 1'b0;
        last_m = NR - 1;
        rd_m = '0;
        txn(2'b11, 2'b00, {8'h91, 8'h19}, 16'h0, 8'h3D, 0, 1'b0, w);
        chk("mrst_first", w, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 11);
            d = (r < 9) ? (r % 4) : ((r == 9) ? TO - 1 : -1);
            a0 = AW'($urandom);
            txn(NR'($urandom_range(1, 3)), NR'($urandom), {a0 ^ 8'h80, a0},
                16'($urandom), DW'($urandom), d, 1'($urandom), w);
        end
        i_Req = '0;
        repeat (2) @(negedge i_Clock);
        chk("idle_cyc", o_wb_cyc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
